// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, op encoding and mstatus field layout
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;

  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;

endpackage

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - free-running counter with a software write port that beats the increment
module csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc,
  input  logic            wen,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] value
);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else if (wen) begin
      value <= wdata;
    end else if (inc) begin
      value <= value + XLEN'(1);
    end
  end

endmodule

// File: rtl/csr_file_m.sv
// rtl/csr_file_m.sv - machine-mode CSR file with trap entry, MRET and cycle/instret counters
module csr_file_m
  import csr_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] HART_ID     = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_src,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret_valid,
  input  logic            instret_inc,
  output logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] mret_pc,
  output logic            irq_en
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  csr_op_e         op;
  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;
  logic [XLEN-1:0] mstatus_rd;
  logic            addr_known;
  logic [XLEN-1:0] wdata;
  logic            wen;

  assign op = csr_op_e'(csr_op);

  always_comb begin
    mstatus_rd                                 = '0;
    mstatus_rd[MSTATUS_MIE_BIT]                = mie;
    mstatus_rd[MSTATUS_MPIE_BIT]               = mpie;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
  end

  always_comb begin
    csr_rdata  = '0;
    addr_known = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_rd;
      CSR_MTVEC:    csr_rdata = mtvec;
      CSR_MSCRATCH: csr_rdata = mscratch;
      CSR_MEPC:     csr_rdata = mepc;
      CSR_MCAUSE:   csr_rdata = mcause;
      CSR_MCYCLE:   csr_rdata = mcycle;
      CSR_MINSTRET: csr_rdata = minstret;
      CSR_MHARTID:  csr_rdata = HART_ID;
      default:      addr_known = 1'b0;
    endcase
  end

  // mhartid tolerates only the no-op forms (set/clear with a zero mask).
  always_comb begin
    csr_illegal = 1'b0;
    if (op != CSR_NONE) begin
      if (!addr_known) begin
        csr_illegal = 1'b1;
      end else if (csr_addr == CSR_MHARTID) begin
        csr_illegal = (op == CSR_RW) || (csr_src != '0);
      end
    end
  end

  always_comb begin
    wdata = csr_rdata;
    case (op)
      CSR_RW:  wdata = csr_src;
      CSR_RS:  wdata = csr_rdata | csr_src;
      CSR_RC:  wdata = csr_rdata & ~csr_src;
      default: wdata = csr_rdata;
    endcase
  end

  // A trap or MRET squashes the instruction issuing the CSR access.
  assign wen = (op != CSR_NONE) && !csr_illegal && !trap_valid && !mret_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET & ALIGN_MASK;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else if (trap_valid) begin
      mepc   <= trap_pc & ALIGN_MASK;
      mcause <= trap_cause;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret_valid) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (wen) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie  <= wdata[MSTATUS_MIE_BIT];
          mpie <= wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MTVEC:    mtvec    <= wdata & ALIGN_MASK;
        CSR_MSCRATCH: mscratch <= wdata;
        CSR_MEPC:     mepc     <= wdata & ALIGN_MASK;
        CSR_MCAUSE:   mcause   <= wdata;
        default: ;
      endcase
    end
  end

  csr_counter #(.XLEN(XLEN)) u_mcycle (
    .clock (clock),
    .reset (reset),
    .inc   (1'b1),
    .wen   (wen && (csr_addr == CSR_MCYCLE)),
    .wdata (wdata),
    .value (mcycle)
  );

  csr_counter #(.XLEN(XLEN)) u_minstret (
    .clock (clock),
    .reset (reset),
    .inc   (instret_inc),
    .wen   (wen && (csr_addr == CSR_MINSTRET)),
    .wdata (wdata),
    .value (minstret)
  );

  assign trap_vec = mtvec;
  assign mret_pc  = mepc;
  assign irq_en   = mie;

endmodule

// File: tb/tb_csr_file_m.sv
// tb/tb_csr_file_m.sv - randomized scoreboard bench for csr_file_m against a behavioural CSR model
module tb_csr_file_m;

  localparam logic [63:0] HART_ID     = 64'd3;
  localparam logic [63:0] MTVEC_RESET = 64'h0000_0000_8000_0007;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] csr_addr = '0;
  logic [1:0]  csr_op = '0;
  logic [63:0] csr_src = '0;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid = 1'b0;
  logic [63:0] trap_pc = '0;
  logic [63:0] trap_cause = '0;
  logic        mret_valid = 1'b0;
  logic        instret_inc = 1'b0;
  logic [63:0] trap_vec;
  logic [63:0] mret_pc;
  logic        irq_en;

  csr_file_m #(.XLEN(64), .HART_ID(HART_ID), .MTVEC_RESET(MTVEC_RESET)) dut (
    .clock       (clock),
    .reset       (reset),
    .csr_addr    (csr_addr),
    .csr_op      (csr_op),
    .csr_src     (csr_src),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .trap_valid  (trap_valid),
    .trap_pc     (trap_pc),
    .trap_cause  (trap_cause),
    .mret_valid  (mret_valid),
    .instret_inc (instret_inc),
    .trap_vec    (trap_vec),
    .mret_pc     (mret_pc),
    .irq_en      (irq_en)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [63:0] rdata;
    logic        illegal;
    logic [63:0] tvec;
    logic [63:0] mpc;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;
  bit   drive_done = 1'b0;

  // Architectural state of the reference model.
  bit          m_mie, m_mpie;
  logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = MTVEC_RESET & ~64'd3;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mcycle = 0; m_minstret = 0;
  endfunction

  function automatic logic [63:0] model_read(logic [11:0] a);
    case (a)
      12'h300: return 64'h1800 + (m_mie ? 64'd8 : 64'd0) + (m_mpie ? 64'd128 : 64'd0);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      12'hF14: return HART_ID;
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit model_illegal(logic [11:0] a, logic [1:0] o, logic [63:0] s);
    if (o == 2'b00) return 0;
    case (a)
      12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02: return 0;
      12'hF14: return (o == 2'b01) || (s != 0);
      default: return 1;
    endcase
  endfunction

  function automatic void model_step(logic [11:0] a, logic [1:0] o, logic [63:0] s,
                                     bit tv, logic [63:0] pc, logic [63:0] cause,
                                     bit mv, bit inc);
    logic [63:0] old, nv;
    bit          w;
    old = model_read(a);
    nv  = (o == 2'b01) ? s : (o == 2'b10) ? (old | s) : (old & ~s);
    w   = (o != 2'b00) && !model_illegal(a, o, s) && !tv && !mv;
    m_mcycle   = m_mcycle + 1;
    m_minstret = m_minstret + (inc ? 64'd1 : 64'd0);
    if (tv) begin
      m_mepc   = pc & ~64'd3;
      m_mcause = cause;
      m_mpie   = m_mie;
      m_mie    = 0;
    end else if (mv) begin
      m_mie  = m_mpie;
      m_mpie = 1;
    end else if (w) begin
      case (a)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec    = nv & ~64'd3;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & ~64'd3;
        12'h342: m_mcause   = nv;
        12'hB00: m_mcycle   = nv;
        12'hB02: m_minstret = nv;
        default: ;
      endcase
    end
  endfunction

  // One clock of stimulus; use_k replaces the model's read prediction with a hand-derived constant.
  task automatic step(input logic [11:0] a, input logic [1:0] o, input logic [63:0] s,
                      input bit tv, input logic [63:0] pc, input logic [63:0] cause,
                      input bit mv, input bit inc, input bit use_k, input logic [63:0] k);
    exp_t e;
    csr_addr = a; csr_op = o; csr_src = s;
    trap_valid = tv; trap_pc = pc; trap_cause = cause;
    mret_valid = mv; instret_inc = inc;
    e.id      = step_id;
    e.rdata   = use_k ? k : model_read(a);
    e.illegal = model_illegal(a, o, s);
    e.tvec    = m_mtvec;
    e.mpc     = m_mepc;
    e.irq     = m_mie;
    exp_q.push_back(e);
    step_id++;
    @(posedge clock);
    model_step(a, o, s, tv, pc, cause, mv, inc);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] k);
    step(a, 2'b00, 64'd0, 0, 64'd0, 64'd0, 0, 0, 1, k);
  endtask

  task automatic op_k(input logic [11:0] a, input logic [1:0] o, input logic [63:0] s, input logic [63:0] k);
    step(a, o, s, 0, 64'd0, 64'd0, 0, 0, 1, k);
  endtask

  task automatic chk64(input string name, input int id, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step=%0d got=%h want=%h", name, id, got, want);
    end
  endtask

  // Monitor: the DUT presents a response every driven cycle; check it mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk64("rdata",    e.id, csr_rdata,           e.rdata);
      chk64("illegal",  e.id, {63'd0, csr_illegal}, {63'd0, e.illegal});
      chk64("trap_vec", e.id, trap_vec,            e.tvec);
      chk64("mret_pc",  e.id, mret_pc,             e.mpc);
      chk64("irq_en",   e.id, {63'd0, irq_en},      {63'd0, e.irq});
    end
  end

  logic [11:0] addr_tbl [11] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'h301, 12'hB80};

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    rd(12'hB00, 64'd0);
    rd(12'h300, 64'h1800);
    rd(12'h305, 64'h8000_0004);
    rd(12'h340, 64'd0);
    rd(12'h341, 64'd0);
    rd(12'h342, 64'd0);
    rd(12'hB02, 64'd0);
    rd(12'hF14, 64'd3);

    op_k(12'h340, 2'b01, 64'hF0F0, 64'd0);
    op_k(12'h340, 2'b10, 64'h000F, 64'hF0F0);
    op_k(12'h340, 2'b11, 64'h00F0, 64'hF0FF);
    rd(12'h340, 64'hF00F);

    op_k(12'h300, 2'b01, 64'h8, 64'h1800);
    step(12'h341, 2'b00, 0, 1, 64'h8000_0102, 64'd11, 0, 0, 1, 64'd0);
    rd(12'h341, 64'h8000_0100);
    rd(12'h342, 64'd11);
    rd(12'h300, 64'h1880);
    step(12'h300, 2'b00, 0, 0, 0, 0, 1, 1, 1, 64'h1880);
    rd(12'h300, 64'h1888);

    step(12'h305, 2'b01, 64'h1000, 1, 64'h200, 64'd2, 1, 0, 1, 64'h8000_0004);
    rd(12'h300, 64'h1880);
    rd(12'h305, 64'h8000_0004);
    rd(12'h341, 64'h200);

    op_k(12'hF14, 2'b01, 64'd5, 64'd3);
    rd(12'hF14, 64'd3);
    op_k(12'h7C0, 2'b01, 64'd9, 64'd0);
    op_k(12'hF14, 2'b10, 64'd0, 64'd3);

    step(12'hB00, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0, 0, 0);
    rd(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    rd(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB00, 64'd0);
    step(12'hB02, 2'b01, 64'h100, 0, 0, 0, 0, 1, 0, 0);
    rd(12'hB02, 64'h100);

    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      logic [63:0] s;
      a = addr_tbl[$urandom_range(0, 10)];
      s = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      step(a, 2'($urandom_range(0, 3)), s,
           ($urandom_range(0, 15) == 0), {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 0, 0);
    end

    @(negedge clock);
    #1;
    drive_done = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
